keccak_absorb_frontend: RTL and testbench

Input front-end of the Keccak/SHA-3 core.
- Collects 64-bit message words into a rate-sized block and applies SHA-3/SHAKE multi-rate padding.
- XORs the block into the chaining state (or into zero for the first block).
- Presents the 1600-bit absorbed state, as a flat string and as a lane array, to the permutation pipeline.

---
 rtl/keccak_pkg.sv | 34 +++
 rtl/keccak_str2lanes.sv | 18 +
 rtl/keccak_absorb_frontend.sv | 169 ++++++++++++++++
 tb/tb_keccak_absorb_frontend.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared types and constants for the Keccak absorb front-end.
package keccak_pkg;

  typedef logic [63:0] lane_t;
  // Indexed [x][y]; lane (x,y) occupies string bits 64*(5y+x) +: 64.
  typedef lane_t [4:0][4:0] state_t;

  // Rate in 64-bit words for cmode 0..5.
  localparam int RATE_WORDS [6] = '{18, 17, 13, 9, 21, 17};

  localparam logic [7:0] DOM_SHA3  = 8'h06;
  localparam logic [7:0] DOM_SHAKE = 8'h1F;

  // Rate in words; the undefined modes 6/7 fall back to SHA3-256.
  function automatic logic [4:0] rate_of(input logic [2:0] m);
    logic [4:0] r;
    case (m)
      3'd0:    r = 5'(RATE_WORDS[0]);
      3'd1:    r = 5'(RATE_WORDS[1]);
      3'd2:    r = 5'(RATE_WORDS[2]);
      3'd3:    r = 5'(RATE_WORDS[3]);
      3'd4:    r = 5'(RATE_WORDS[4]);
      3'd5:    r = 5'(RATE_WORDS[5]);
      default: r = 5'(RATE_WORDS[1]);
    endcase
    return r;
  endfunction

  // Domain-separation byte: SHAKE modes use 0x1F, everything else 0x06.
  function automatic logic [7:0] dom_of(input logic [2:0] m);
    return (m == 3'd4 || m == 3'd5) ? DOM_SHAKE : DOM_SHA3;
  endfunction

endpackage

// File: rtl/keccak_str2lanes.sv
// Pure wiring: 1600-bit state string to the 5x5 lane array.
module keccak_str2lanes
  import keccak_pkg::*;
(
  input  logic [1599:0] state_str,
  output state_t        lanes
);

  genvar gi, gj;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_x
      for (gj = 0; gj < 5; gj++) begin : g_y
        assign lanes[gi][gj] = state_str[64*(5*gj+gi) +: 64];
      end
    end
  endgenerate

endmodule

// File: rtl/keccak_absorb_frontend.sv
// Message-word collector, multi-rate padder and absorb XOR for the Keccak core.
module keccak_absorb_frontend
  import keccak_pkg::*;
#(
  parameter int W    = 64,
  parameter int MAXR = 1344
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    cmode,
  input  logic [W-1:0]  dt_i,
  input  logic          dt_vld,
  input  logic          last_word,
  output logic          in_ready,
  input  logic [1599:0] chain_i,
  input  logic          blk_ack,
  output logic          blk_valid,
  output logic          blk_first,
  output logic          blk_last,
  output logic [1599:0] state_o,
  output state_t        lanes_o
);

  localparam int NB = MAXR / W;   // buffer words
  localparam int SW = 1600 / W;   // state words

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;
  localparam logic [1:0] ST_PADBLK = 2'd3;

  logic [1:0]      st_reg;
  logic [2:0]      mode_reg;
  logic [4:0]      k_reg;
  logic            first_reg;
  logic            final_reg;
  logic            pend_reg;
  logic [MAXR-1:0] buf_reg;
  logic [MAXR-1:0] buf_next;
  logic [1599:0]   state_reg;
  logic [1599:0]   absorbed;

  logic [4:0] nw;
  logic [4:0] nw_m1;
  logic [4:0] k_p1;
  logic [7:0] dom;
  logic       accept;
  logic       k_last;
  logic       pad_now;

  assign nw      = rate_of(mode_reg);
  assign nw_m1   = nw - 5'd1;
  assign k_p1    = k_reg + 5'd1;
  assign dom     = dom_of(mode_reg);
  assign accept  = (st_reg == ST_FILL) && dt_vld;
  assign k_last  = (k_reg == nw_m1);
  assign pad_now = accept && last_word && !k_last;

  assign in_ready  = (st_reg == ST_FILL);
  assign blk_valid = (st_reg == ST_FULL);
  assign blk_first = first_reg && (st_reg == ST_FULL);
  assign blk_last  = final_reg && (st_reg == ST_FULL);
  assign state_o   = state_reg;

  genvar gi;
  generate
    // Next buffer contents, word by word: data write, in-line padding, or a pure pad block.
    for (gi = 0; gi < NB; gi++) begin : g_buf
      logic [W-1:0] word;
      always_comb begin
        word = buf_reg[gi*W +: W];
        if (st_reg == ST_PADBLK) begin
          word = '0;
          if (gi == 0) word[7:0] = dom;
          if (5'(gi) == nw_m1) word[W-1] = 1'b1;
        end else if (accept) begin
          if (5'(gi) == k_reg) begin
            word = dt_i;
          end else if (pad_now) begin
            if (5'(gi) == k_p1) word = {{(W-8){1'b0}}, dom};
            if (5'(gi) == nw_m1) word[W-1] = 1'b1;
          end
        end
      end
      assign buf_next[gi*W +: W] = word;
    end

    // Absorb: only words below the rate reach the state; capacity passes the chain through.
    for (gi = 0; gi < SW; gi++) begin : g_abs
      logic [W-1:0] rate_word;
      if (gi < NB) begin : g_rate
        assign rate_word = (5'(gi) < nw) ? buf_next[gi*W +: W] : '0;
      end else begin : g_cap
        assign rate_word = '0;
      end
      assign absorbed[gi*W +: W] = (first_reg ? '0 : chain_i[gi*W +: W]) ^ rate_word;
    end
  endgenerate

  keccak_str2lanes u_lanes (
    .state_str (state_reg),
    .lanes     (lanes_o)
  );

  // Control FSM, buffer and presented-state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_reg    <= ST_IDLE;
      mode_reg  <= 3'd0;
      k_reg     <= 5'd0;
      first_reg <= 1'b0;
      final_reg <= 1'b0;
      pend_reg  <= 1'b0;
      buf_reg   <= '0;
      state_reg <= '0;
    end else begin
      case (st_reg)
        ST_IDLE: begin
          if (start) begin
            mode_reg  <= cmode;
            k_reg     <= 5'd0;
            first_reg <= 1'b1;
            final_reg <= 1'b0;
            pend_reg  <= 1'b0;
            buf_reg   <= '0;
            st_reg    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (accept) begin
            buf_reg <= buf_next;
            if (last_word || k_last) begin
              // A last word that exactly fills the block leaves no room; pad goes in its own block.
              pend_reg  <= last_word && k_last;
              final_reg <= last_word && !k_last;
              state_reg <= absorbed;
              st_reg    <= ST_FULL;
            end else begin
              k_reg <= k_p1;
            end
          end
        end
        ST_FULL: begin
          if (blk_ack) begin
            first_reg <= 1'b0;
            if (final_reg) begin
              st_reg <= ST_IDLE;
            end else if (pend_reg) begin
              pend_reg <= 1'b0;
              st_reg   <= ST_PADBLK;
            end else begin
              k_reg   <= 5'd0;
              buf_reg <= '0;
              st_reg  <= ST_FILL;
            end
          end
        end
        default: begin
          buf_reg   <= buf_next;
          state_reg <= absorbed;
          final_reg <= 1'b1;
          st_reg    <= ST_FULL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_absorb_frontend.sv
// Directed self-checking bench for keccak_absorb_frontend.
module tb_keccak_absorb_frontend;
  import keccak_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    cmode = 3'd0;
  logic [63:0]   dt_i = '0;
  logic          dt_vld = 1'b0;
  logic          last_word = 1'b0;
  logic          in_ready;
  logic [1599:0] chain_i = '0;
  logic          blk_ack = 1'b0;
  logic          blk_valid;
  logic          blk_first;
  logic          blk_last;
  logic [1599:0] state_o;
  state_t        lanes_o;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] TOP  = 64'h8000_0000_0000_0000;

  keccak_absorb_frontend dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cmode     (cmode),
    .dt_i      (dt_i),
    .dt_vld    (dt_vld),
    .last_word (last_word),
    .in_ready  (in_ready),
    .chain_i   (chain_i),
    .blk_ack   (blk_ack),
    .blk_valid (blk_valid),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .state_o   (state_o),
    .lanes_o   (lanes_o)
  );

  always #5 clk = ~clk;

  function automatic logic [1599:0] chain_pat();
    logic [1599:0] c;
    for (int i = 0; i < 25; i++) c[i*64 +: 64] = 64'hC0DE_0000_0000_0000 | 64'(i);
    return c;
  endfunction

  function automatic logic [63:0] wd(input int i);
    return state_o[i*64 +: 64];
  endfunction

  task automatic do_start(input logic [2:0] m);
    @(negedge clk); start = 1'b1; cmode = m;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] d, input logic l);
    @(negedge clk); dt_i = d; dt_vld = 1'b1; last_word = l;
    @(negedge clk); dt_vld = 1'b0; last_word = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk); blk_ack = 1'b1;
    @(negedge clk); blk_ack = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!blk_valid && n < 20) begin @(negedge clk); n++; end
    tests_run++;
    if (blk_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_valid_timeout got=%b want=1", tag, blk_valid);
    end
    $display("[TB] %s block presented first=%b last=%b w0=%h", tag, blk_first, blk_last, wd(0));
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({in_ready, blk_valid, blk_first, blk_last} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags got=%b want=0000", {in_ready, blk_valid, blk_first, blk_last});
    end
    tests_run++;
    if (state_o !== '0 || lanes_o !== '0) begin
      tests_failed++;
      $display("FAIL reset_state got_w0=%h want=0", wd(0));
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // SHA3-512 single all-ones word, chain must be ignored on block 0.
  task automatic test_sha3_512_single();
    chain_i = chain_pat();
    do_start(3'd3);
    send_word(ONES, 1'b1);
    tests_run++;
    if ({blk_valid, blk_first, blk_last} !== 3'b111) begin
      tests_failed++;
      $display("FAIL t1_flags got=%b want=111", {blk_valid, blk_first, blk_last});
    end
    $display("[TB] t1 block first=%b last=%b w0=%h", blk_first, blk_last, wd(0));
    tests_run++;
    if (wd(0) !== ONES) begin tests_failed++; $display("FAIL t1_w0 got=%h want=%h", wd(0), ONES); end
    tests_run++;
    if (wd(1) !== 64'h06) begin tests_failed++; $display("FAIL t1_w1 got=%h want=6", wd(1)); end
    for (int i = 2; i < 8; i++) begin
      tests_run++;
      if (wd(i) !== 64'h0) begin tests_failed++; $display("FAIL t1_w%0d got=%h want=0", i, wd(i)); end
    end
    tests_run++;
    if (wd(8) !== TOP) begin tests_failed++; $display("FAIL t1_w8 got=%h want=%h", wd(8), TOP); end
    tests_run++;
    if (state_o[1599:576] !== '0) begin tests_failed++; $display("FAIL t1_capacity got_w9=%h want=0", wd(9)); end
    do_ack();
    tests_run++;
    if ({blk_valid, in_ready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL t1_idle got=%b want=00", {blk_valid, in_ready});
    end
  endtask

  // SHAKE256 single zero word; also checks the lane mapping.
  task automatic test_shake256_zero();
    do_start(3'd5);
    send_word(64'h0, 1'b1);
    $display("[TB] t2 block first=%b last=%b w1=%h", blk_first, blk_last, wd(1));
    tests_run++;
    if (wd(0) !== 64'h0 || wd(1) !== 64'h1F) begin
      tests_failed++;
      $display("FAIL t2_w0w1 got=%h,%h want=0,1f", wd(0), wd(1));
    end
    tests_run++;
    if (wd(16) !== TOP || wd(15) !== 64'h0 || wd(17) !== 64'h0) begin
      tests_failed++;
      $display("FAIL t2_w16 got=%h (w15=%h w17=%h) want=%h", wd(16), wd(15), wd(17), TOP);
    end
    tests_run++;
    if (lanes_o[1][0] !== 64'h1F) begin tests_failed++; $display("FAIL t2_lane10 got=%h want=1f", lanes_o[1][0]); end
    tests_run++;
    if (lanes_o[1][3] !== TOP) begin tests_failed++; $display("FAIL t2_lane13 got=%h want=%h", lanes_o[1][3], TOP); end
    do_ack();
  endtask

  // SHA3-512 exactly filling a block: pad spills into a second block over the chain.
  task automatic test_multi_block();
    logic [1599:0] c;
    c = chain_pat();
    chain_i = c;
    do_start(3'd3);
    for (int i = 0; i < 9; i++) send_word(ONES, i == 8);
    $display("[TB] t3 block1 first=%b last=%b w0=%h", blk_first, blk_last, wd(0));
    tests_run++;
    if ({blk_valid, blk_first, blk_last} !== 3'b110) begin
      tests_failed++;
      $display("FAIL t3_b1_flags got=%b want=110", {blk_valid, blk_first, blk_last});
    end
    tests_run++;
    if (state_o[575:0] !== {576{1'b1}} || state_o[1599:576] !== '0) begin
      tests_failed++;
      $display("FAIL t3_b1_data got_w8=%h w9=%h want=%h,0", wd(8), wd(9), ONES);
    end
    do_ack();
    wait_valid("t3_b2");
    tests_run++;
    if ({blk_first, blk_last} !== 2'b01) begin
      tests_failed++;
      $display("FAIL t3_b2_flags got=%b want=01", {blk_first, blk_last});
    end
    tests_run++;
    if (wd(0) !== (64'h06 ^ c[63:0])) begin
      tests_failed++;
      $display("FAIL t3_b2_w0 got=%h want=%h", wd(0), 64'h06 ^ c[63:0]);
    end
    tests_run++;
    if (wd(8) !== (TOP ^ c[8*64 +: 64])) begin
      tests_failed++;
      $display("FAIL t3_b2_w8 got=%h want=%h", wd(8), TOP ^ c[8*64 +: 64]);
    end
    tests_run++;
    if (state_o[511:64] !== c[511:64] || state_o[1599:576] !== c[1599:576]) begin
      tests_failed++;
      $display("FAIL t3_b2_rest got_w1=%h w9=%h want=%h,%h", wd(1), wd(9), c[127:64], c[639:576]);
    end
    do_ack();
  endtask

  // Non-first, non-final block XORed over an all-ones chain.
  task automatic test_chain_xor();
    logic [63:0] d;
    chain_i = '0;
    do_start(3'd3);
    for (int i = 0; i < 9; i++) send_word(64'h1, 1'b0);
    do_ack();
    chain_i = {1600{1'b1}};
    for (int i = 0; i < 9; i++) send_word(64'h1111_0000_0000_0000 * 64'(i), 1'b0);
    $display("[TB] t4 block2 first=%b last=%b w1=%h", blk_first, blk_last, wd(1));
    tests_run++;
    if ({blk_valid, blk_first, blk_last} !== 3'b100) begin
      tests_failed++;
      $display("FAIL t4_flags got=%b want=100", {blk_valid, blk_first, blk_last});
    end
    for (int i = 0; i < 9; i++) begin
      d = 64'h1111_0000_0000_0000 * 64'(i);
      tests_run++;
      if (wd(i) !== ~d) begin tests_failed++; $display("FAIL t4_w%0d got=%h want=%h", i, wd(i), ~d); end
    end
    tests_run++;
    if (state_o[1599:576] !== {1024{1'b1}}) begin
      tests_failed++;
      $display("FAIL t4_capacity got_w9=%h want=%h", wd(9), ONES);
    end
    // Close the message cleanly.
    do_ack();
    send_word(64'h0, 1'b1);
    wait_valid("t4_close");
    do_ack();
  endtask

  // SHA3-224: last word one short of the rate, domain and final bit share a word.
  task automatic test_sha3_224();
    chain_i = chain_pat();
    do_start(3'd0);
    for (int i = 0; i < 17; i++) send_word(64'(i + 1), i == 16);
    $display("[TB] t5 block first=%b last=%b w17=%h", blk_first, blk_last, wd(17));
    tests_run++;
    if ({blk_valid, blk_first, blk_last} !== 3'b111) begin
      tests_failed++;
      $display("FAIL t5_flags got=%b want=111", {blk_valid, blk_first, blk_last});
    end
    for (int i = 0; i < 17; i++) begin
      tests_run++;
      if (wd(i) !== 64'(i + 1)) begin tests_failed++; $display("FAIL t5_w%0d got=%h want=%h", i, wd(i), 64'(i + 1)); end
    end
    tests_run++;
    if (wd(17) !== 64'h8000_0000_0000_0006) begin
      tests_failed++;
      $display("FAIL t5_w17 got=%h want=8000000000000006", wd(17));
    end
    tests_run++;
    if (state_o[1599:1152] !== '0) begin tests_failed++; $display("FAIL t5_capacity got_w18=%h want=0", wd(18)); end
    do_ack();
  endtask

  // Reset mid-fill discards everything; next message is clean.
  task automatic test_reset_mid();
    do_start(3'd1);
    for (int i = 0; i < 4; i++) send_word(64'hDEAD_BEEF_0000_0000 | 64'(i), 1'b0);
    @(negedge clk); rst = 1'b1;
    #1;
    tests_run++;
    if ({in_ready, blk_valid, blk_first, blk_last} !== 4'b0000 || state_o !== '0 || lanes_o !== '0) begin
      tests_failed++;
      $display("FAIL t6_async_reset flags=%b w0=%h want=0000,0", {in_ready, blk_valid, blk_first, blk_last}, wd(0));
    end
    @(negedge clk); rst = 1'b0;
    do_start(3'd1);
    send_word(64'hAAAA, 1'b1);
    $display("[TB] t6 block first=%b last=%b w0=%h", blk_first, blk_last, wd(0));
    tests_run++;
    if ({blk_valid, blk_first, blk_last} !== 3'b111) begin
      tests_failed++;
      $display("FAIL t6_flags got=%b want=111", {blk_valid, blk_first, blk_last});
    end
    tests_run++;
    if (wd(0) !== 64'hAAAA || wd(1) !== 64'h06 || wd(2) !== 64'h0 || wd(3) !== 64'h0) begin
      tests_failed++;
      $display("FAIL t6_words got=%h,%h,%h,%h want=aaaa,6,0,0", wd(0), wd(1), wd(2), wd(3));
    end
    tests_run++;
    if (wd(16) !== TOP || state_o[1599:1088] !== '0) begin
      tests_failed++;
      $display("FAIL t6_tail got_w16=%h w17=%h want=%h,0", wd(16), wd(17), TOP);
    end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_sha3_512_single();
    test_shake256_zero();
    test_multi_block();
    test_chain_xor();
    test_sha3_224();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
